// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices.
// Each stage ripples one slice; carries, unconsumed operands and finished slices move forward together.
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // b is stored already conditioned by op, so op needs no further transport.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  logic   en;

  assign en        = !stage_q[STAGES-1].vld || out_ready;
  assign in_ready  = en;
  assign out_valid = stage_q[STAGES-1].vld;
  assign s         = stage_q[STAGES-1].s;
  assign co        = stage_q[STAGES-1].c;
  assign ovf       = stage_q[STAGES-1].ovf;

  always_comb begin : stage_comb
    stage_t src;
    stage_t nxt;
    logic   carry;
    logic   c_msb;

    src     = '0;
    src.vld = in_valid;
    src.a   = a;
    src.b   = op ? ~b : b;
    src.c   = op ? 1'b1 : ci;

    for (int k = 0; k < STAGES; k++) begin
      nxt   = src;
      carry = src.c;
      c_msb = 1'b0;
      // NOTE: blocking assignments here are intentional: carry must ripple
      // bit-to-bit within one evaluation, which only works combinationally.
      for (int i = 0; i < SW; i++) begin
        if (k * SW + i == WIDTH - 1) c_msb = carry;
        nxt.s[k*SW+i] = src.a[k*SW+i] ^ src.b[k*SW+i] ^ carry;
        carry = (src.a[k*SW+i] & src.b[k*SW+i]) |
                (carry & (src.a[k*SW+i] ^ src.b[k*SW+i]));
      end
      nxt.c   = carry;
      // Only meaningful in the last slice, where c_msb is the carry into the MSB.
      nxt.ovf = c_msb ^ carry;

      stage_d[k] = en ? nxt : stage_q[k];
      src        = stage_q[k];
    end
  end

  // NOTE: data registers are reset too (not just valids), because s/co/ovf
  // must read zero while reset is held, not whatever was in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed corner cases on a 16x4 instance,
// and a randomized sweep across (8,1), (32,8) and (16,16) against an arithmetic model.
module tb_pipe_addsub;

  typedef struct packed {
    logic        vld;
    logic        ovf;
    logic        co;
    logic [31:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, s;
  logic        ci, op, co, ovf;

  logic        sw_in_valid, sw_out_ready;
  logic [31:0] sw_a, sw_b;
  logic        sw_ci, sw_op;
  logic        w8_in_ready, w8_out_valid, w8_co, w8_ovf;
  logic [7:0]  w8_s;
  logic        w32_in_ready, w32_out_valid, w32_co, w32_ovf;
  logic [31:0] w32_s;
  logic        w16_in_ready, w16_out_valid, w16_co, w16_ovf;
  logic [15:0] w16_s;

  int checks   = 0;
  int failures = 0;

  exp_t h8 [4096];
  exp_t h32[4096];
  exp_t h16[4096];

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  pipe_addsub #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid), .in_ready(w8_in_ready),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .op(sw_op), .out_valid(w8_out_valid),
    .out_ready(sw_out_ready), .s(w8_s), .co(w8_co), .ovf(w8_ovf)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(8)) u_w32 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid), .in_ready(w32_in_ready),
    .a(sw_a), .b(sw_b), .ci(sw_ci), .op(sw_op), .out_valid(w32_out_valid),
    .out_ready(sw_out_ready), .s(w32_s), .co(w32_co), .ovf(w32_ovf)
  );

  pipe_addsub #(.WIDTH(16), .STAGES(16)) u_w16 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid), .in_ready(w16_in_ready),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .ci(sw_ci), .op(sw_op), .out_valid(w16_out_valid),
    .out_ready(sw_out_ready), .s(w16_s), .co(w16_co), .ovf(w16_ovf)
  );

  // Reference: integer add/subtract modulo 2^w; overflow from the true signed result.
  function automatic exp_t ref_calc(int w, logic [31:0] av, logic [31:0] bv,
                                    logic civ, logic opv);
    exp_t   r;
    longint modv, half, ua, ub, sa, sb, u, sr;
    modv = longint'(1) << w;
    half = modv / 2;
    ua   = longint'(av) & (modv - 1);
    ub   = longint'(bv) & (modv - 1);
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    r    = '0;
    if (!opv) begin
      u    = ua + ub + longint'(civ);
      sr   = sa + sb + longint'(civ);
      r.co = (u >= modv);
      if (u >= modv) u = u - modv;
    end else begin
      u    = ua - ub;
      sr   = sa - sb;
      r.co = (ua >= ub);
      if (u < 0) u = u + modv;
    end
    r.vld = 1'b1;
    r.s   = u[31:0];
    r.ovf = (sr >= half) || (sr < -half);
    return r;
  endfunction

  // Stimulus helper: issue one operation with out_ready high and report what came out.
  task automatic run_single(input logic [15:0] ta, input logic [15:0] tbv,
                            input logic tci, input logic top,
                            output logic [15:0] rs, output logic rco,
                            output logic rovf, output int lat);
    out_ready = 1'b1;
    a = ta; b = tbv; ci = tci; op = top;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rco = co; rovf = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; op = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_op = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b s=%h co=%b ovf=%b, want 0 0000 0 0",
               out_valid, s, co, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_valid: got %b, want 0", out_valid);
    end
  endtask

  task automatic test_add_wrap();
    logic [15:0] rs; logic rco, rovf; int lat;
    run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_wrap: got s=%h co=%b ovf=%b, want 0000 1 0", rs, rco, rovf);
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL add_wrap_latency: got %0d edges, want 4", lat);
    end
  endtask

  task automatic test_signed_ovf();
    logic [15:0] rs; logic rco, rovf; int lat;
    run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'h8000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_ovf: got s=%h co=%b ovf=%b, want 8000 0 1", rs, rco, rovf);
    end
    run_single(16'h1234, 16'h0F0F, 1'b1, 1'b0, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'h2144, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_ci: got s=%h co=%b ovf=%b, want 2144 0 0", rs, rco, rovf);
    end
  endtask

  task automatic test_subtract();
    logic [15:0] rs; logic rco, rovf; int lat;
    run_single(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_borrow: got s=%h co=%b ovf=%b, want fffe 0 0", rs, rco, rovf);
    end
    run_single(16'h8000, 16'h0001, 1'b1, 1'b1, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_ovf: got s=%h co=%b ovf=%b, want 7fff 1 1", rs, rco, rovf);
    end
  endtask

  task automatic test_backpressure();
    exp_t        q[$];
    exp_t        e;
    logic [15:0] ta[8], tbv[8];
    logic        tci[8], top[8];
    logic        acc, ret, held;
    logic [17:0] snap;
    int sent = 0, got = 0, cyc = 0, stalls = 0;
    for (int i = 0; i < 8; i++) begin
      ta[i]  = 16'($urandom);
      tbv[i] = 16'($urandom);
      tci[i] = 1'($urandom_range(0, 1));
      top[i] = 1'($urandom_range(0, 1));
    end
    while (got < 8 && cyc < 60) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = ta[sent]; b = tbv[sent]; ci = tci[sent]; op = top[sent];
      end
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      acc  = in_valid && in_ready;
      ret  = out_valid && out_ready;
      held = out_valid && !out_ready;
      snap = {ovf, co, s};
      if (held) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: cycle %0d got %b, want 0", cyc, in_ready);
        end
      end
      if (ret) begin
        checks++;
        got++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra_result: cycle %0d got s=%h with nothing outstanding", cyc, s);
        end else begin
          e = q.pop_front();
          if (snap !== {e.ovf, e.co, e.s[15:0]}) begin
            failures++;
            $display("FAIL bp_result: got ovf/co/s=%b/%b/%h, want %b/%b/%h",
                     ovf, co, s, e.ovf, e.co, e.s[15:0]);
          end
        end
      end
      @(posedge clk); #1;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, co, s} !== snap) begin
          failures++;
          $display("FAIL stall_hold: got v=%b ovf/co/s=%b/%b/%h, want 1 and %h",
                   out_valid, ovf, co, s, snap);
        end
      end
      if (acc) begin
        q.push_back(ref_calc(16, {16'h0, ta[sent]}, {16'h0, tbv[sent]}, tci[sent], top[sent]));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8 || sent != 8 || q.size() != 0 || stalls != 3) begin
      failures++;
      $display("FAIL bp_counts: got sent=%0d retired=%0d left=%0d stalls=%0d, want 8 8 0 3",
               sent, got, q.size(), stalls);
    end
    got = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) got++;
    end
    checks++;
    if (got != 0) begin
      failures++;
      $display("FAIL bp_duplicate: got %0d extra valid cycles, want 0", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rs; logic rco, rovf; int lat, stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'b0; op = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b, want 1", out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got v=%b s=%h co=%b ovf=%b rdy=%b, want 0 0000 0 0 1",
               out_valid, s, co, ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    run_single(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rco, rovf, lat);
    checks++;
    if ({rs, rco, rovf} !== {16'h0002, 1'b0, 1'b0} || lat != 4) begin
      failures++;
      $display("FAIL post_reset_op: got s=%h co=%b ovf=%b lat=%0d, want 0002 0 0 4",
               rs, rco, rovf, lat);
    end
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL stale_results: got %0d valid cycles, want 0", stale);
    end
  endtask

  task automatic test_param_sweep();
    exp_t e;
    int n = 0, accepted = 0, drain = 0;
    while ((accepted < 1000 || drain < 17) && n < 4000) begin
      sw_in_valid = (accepted < 1000) && ($urandom_range(0, 7) != 0);
      sw_a  = $urandom;
      sw_b  = $urandom;
      sw_ci = 1'($urandom_range(0, 1));
      sw_op = 1'($urandom_range(0, 1));
      h8[n]  = sw_in_valid ? ref_calc(8,  sw_a, sw_b, sw_ci, sw_op) : '0;
      h32[n] = sw_in_valid ? ref_calc(32, sw_a, sw_b, sw_ci, sw_op) : '0;
      h16[n] = sw_in_valid ? ref_calc(16, sw_a, sw_b, sw_ci, sw_op) : '0;
      @(posedge clk); #1;
      if (sw_in_valid) accepted++;
      else if (accepted >= 1000) drain++;

      e = h8[n];
      checks++;
      if (w8_out_valid !== e.vld || (e.vld && {w8_ovf, w8_co, w8_s} !== {e.ovf, e.co, e.s[7:0]})) begin
        failures++;
        $display("FAIL sweep_8x1 cyc %0d: got v=%b ovf/co/s=%b/%b/%h, want v=%b %b/%b/%h",
                 n, w8_out_valid, w8_ovf, w8_co, w8_s, e.vld, e.ovf, e.co, e.s[7:0]);
      end
      e = (n >= 7) ? h32[n-7] : '0;
      checks++;
      if (w32_out_valid !== e.vld || (e.vld && {w32_ovf, w32_co, w32_s} !== {e.ovf, e.co, e.s})) begin
        failures++;
        $display("FAIL sweep_32x8 cyc %0d: got v=%b ovf/co/s=%b/%b/%h, want v=%b %b/%b/%h",
                 n, w32_out_valid, w32_ovf, w32_co, w32_s, e.vld, e.ovf, e.co, e.s);
      end
      e = (n >= 15) ? h16[n-15] : '0;
      checks++;
      if (w16_out_valid !== e.vld || (e.vld && {w16_ovf, w16_co, w16_s} !== {e.ovf, e.co, e.s[15:0]})) begin
        failures++;
        $display("FAIL sweep_16x16 cyc %0d: got v=%b ovf/co/s=%b/%b/%h, want v=%b %b/%b/%h",
                 n, w16_out_valid, w16_ovf, w16_co, w16_s, e.vld, e.ovf, e.co, e.s[15:0]);
      end
      n++;
    end
    sw_in_valid = 1'b0;
    checks++;
    if (accepted != 1000) begin
      failures++;
      $display("FAIL sweep_count: got %0d accepted, want 1000", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_signed_ovf();
    test_subtract();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
